// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Per-channel conditioning of raw push-buttons / switches.
//                Each channel has a two-flop synchroniser, a counter-based
//                debounce, a stable level, one-cycle press/release pulses
//                and a sticky press flag with per-bit clear.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
  parameter int NUM_BTN         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] event_flags,
  input  logic [NUM_BTN-1:0] event_clr,
  output logic               any_event
);

  // Largest count a CNT_W-bit counter can hold; evaluated in 64 bits so the
  // range check itself cannot overflow for any sensible CNT_W.
  localparam longint C_CNT_LIMIT = (longint'(1) << CNT_W) - longint'(1);

  // Counter value on which the pending level change is committed.
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations where the counter cannot reach the terminal value.
  generate
    if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) > C_CNT_LIMIT)) begin : g_cfg_error
      $error("button_debouncer: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end
  endgenerate

  // One fully independent conditioning slice per input channel.
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      logic             r_sync1;
      logic             r_sync2;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             r_flag;
      logic [CNT_W-1:0] r_cnt;
      logic             w_differs;
      logic             w_expire;
      logic             w_press_set;

      // The synchronised input disagrees with the committed level.
      assign w_differs   = (r_sync2 != r_level);
      // The disagreement has lasted long enough: commit on this edge.
      assign w_expire    = w_differs && (r_cnt == C_TERMINAL);
      // Same condition that raises the press pulse, so flag and pulse rise together.
      assign w_press_set = w_expire && r_sync2;

      // Two-flop synchroniser for the asynchronous raw input.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= btn_in[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Debounce counter, committed level and single-cycle edge pulses.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (!w_differs) begin
            // Input agrees with level (or bounced back): restart any count.
            r_cnt <= '0;
          end else if (w_expire) begin
            r_cnt     <= '0;
            r_level   <= r_sync2;
            r_press   <= r_sync2;
            r_release <= ~r_sync2;
          end else begin
            // Cannot pass C_TERMINAL: the branch above catches it first.
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      // Sticky press flag; a coincident set takes priority over the clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_flag <= 1'b0;
        end else if (w_press_set) begin
          r_flag <= 1'b1;
        end else if (event_clr[gi]) begin
          r_flag <= 1'b0;
        end
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
      assign event_flags[gi] = r_flag;
    end
  endgenerate

  assign any_event = |event_flags;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4)
//                with directed scenarios and a randomized phase compared
//                against a window-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_debouncer;

  localparam int NUM_BTN = 6;
  localparam int DB      = 4;
  localparam int CNT_W   = 3;

  logic               clk;
  logic               rst;
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] event_flags;
  logic [NUM_BTN-1:0] event_clr;
  logic               any_event;

  int n_assert = 0;
  int n_fail   = 0;

  button_debouncer #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .event_flags(event_flags),
    .event_clr  (event_clr),
    .any_event  (any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the last DB synchronised samples all
  // disagree with it. Inputs reach the debounce stage two edges late.
  logic [NUM_BTN-1:0] m_d1 = '0, m_d2 = '0;
  logic [NUM_BTN-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_flags = '0;
  logic [NUM_BTN-1:0] m_win[$];
  bit                 m_all;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_flags = '0;
      m_win.delete();
    end else begin
      m_win.push_back(m_d2);
      if (m_win.size() > DB) void'(m_win.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        m_all = (m_win.size() == DB);
        for (int k = 0; k < m_win.size(); k++)
          if (m_win[k][i] == m_lvl[i]) m_all = 1'b0;
        if (m_all) begin
          if (m_lvl[i]) m_rel[i] = 1'b1;
          else          m_press[i] = 1'b1;
          m_lvl[i] = ~m_lvl[i];
        end
      end
      m_flags = (m_flags & ~event_clr) | m_press;
      m_d2 = m_d1;
      m_d1 = btn_in;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"},   8'(btn_level),   8'(m_lvl));
    chk({tag, ".press"},   8'(btn_press),   8'(m_press));
    chk({tag, ".release"}, 8'(btn_release), 8'(m_rel));
    chk({tag, ".flags"},   8'(event_flags), 8'(m_flags));
    chk({tag, ".any"},     8'(any_event),   8'(|m_flags));
  endtask

  task automatic settle(input logic [NUM_BTN-1:0] val, input int n);
    btn_in    = val;
    event_clr = '0;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      chk_model("settle");
    end
  endtask

  task automatic clear_all();
    event_clr = '1;
    @(negedge clk);
    chk_model("clear");
    event_clr = '0;
  endtask

  initial begin
    rst       = 1'b1;
    btn_in    = 6'h3F;
    event_clr = '0;

    // Reset held with all inputs high: everything stays low.
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      chk("rst.level", 8'(btn_level),   8'h00);
      chk("rst.press", 8'(btn_press),   8'h00);
      chk("rst.rel",   8'(btn_release), 8'h00);
      chk("rst.flags", 8'(event_flags), 8'h00);
      chk("rst.any",   8'(any_event),   8'h00);
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("post_rst");
      if (e == 5) chk("post_rst.early", 8'(btn_level), 8'h00);
      if (e == 6) begin
        chk("post_rst.level", 8'(btn_level), 8'h3F);
        chk("post_rst.press", 8'(btn_press), 8'h3F);
      end
      if (e == 7) chk("post_rst.press_end", 8'(btn_press), 8'h00);
    end
    clear_all();
    settle('0, 8);
    chk("idle.flags", 8'(event_flags), 8'h00);

    // Clean press and release on channel 0.
    btn_in = 6'h01;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("press0");
      if (e < 6) chk("press0.wait", 8'(btn_press), 8'h00);
      if (e == 6) begin
        chk("press0.level", 8'(btn_level),   8'h01);
        chk("press0.press", 8'(btn_press),   8'h01);
        chk("press0.flags", 8'(event_flags), 8'h01);
        chk("press0.any",   8'(any_event),   8'h01);
      end
      if (e == 7) chk("press0.press_end", 8'(btn_press), 8'h00);
    end
    btn_in = 6'h00;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("rel0");
      if (e == 6) begin
        chk("rel0.release", 8'(btn_release), 8'h01);
        chk("rel0.flags",   8'(event_flags), 8'h01);
      end
      if (e == 7) chk("rel0.release_end", 8'(btn_release), 8'h00);
    end
    clear_all();

    // Bounce on channel 2: high 3, low 2, then held high.
    for (int e = 0; e < 5; e++) begin
      btn_in = (e < 3) ? 6'h04 : 6'h00;
      @(negedge clk);
      chk_model("bounce");
      chk("bounce.nopress", 8'(btn_press), 8'h00);
    end
    btn_in = 6'h04;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("bounce_hold");
      if (e < 6) chk("bounce_hold.wait", 8'(btn_press), 8'h00);
      if (e == 6) chk("bounce_hold.press", 8'(btn_press), 8'h04);
    end
    settle('0, 8);
    // Isolated 3-cycle pulse never reaches the level.
    btn_in = 6'h04;
    for (int e = 0; e < 11; e++) begin
      if (e == 3) btn_in = 6'h00;
      @(negedge clk);
      chk_model("glitch");
      chk("glitch.level2", 8'(btn_level & 6'h04), 8'h00);
    end
    clear_all();

    // Clear coincident with the press condition on channel 1: set wins.
    btn_in = 6'h02;
    for (int e = 1; e <= 8; e++) begin
      event_clr = (e == 6 || e == 7) ? 6'h02 : 6'h00;
      @(negedge clk);
      chk_model("clrset");
      if (e == 6) begin
        chk("clrset.press", 8'(btn_press),   8'h02);
        chk("clrset.flags", 8'(event_flags), 8'h02);
      end
      if (e == 7) begin
        chk("clrset.cleared", 8'(event_flags), 8'h00);
        chk("clrset.any",     8'(any_event),   8'h00);
      end
    end
    settle('0, 8);
    chk("clrset.rel_noflag", 8'(event_flags), 8'h00);

    // Reset in the middle of a count on channel 3.
    btn_in = 6'h08;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk_model("midrst");
      chk("midrst.nopress", 8'(btn_press), 8'h00);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_model("midrst.rst");
    chk("midrst.rst_level", 8'(btn_level), 8'h00);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("midrst.recount");
      if (e < 6) chk("midrst.wait", 8'(btn_press), 8'h00);
      if (e == 6) chk("midrst.press", 8'(btn_press), 8'h08);
    end
    settle('0, 8);
    clear_all();

    // Several channels change together.
    btn_in = 6'h15;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_model("multi");
      if (e == 6) begin
        chk("multi.press", 8'(btn_press),   8'h15);
        chk("multi.flags", 8'(event_flags), 8'h15);
        chk("multi.level", 8'(btn_level),   8'h15);
      end
      if (e == 7) chk("multi.press_end", 8'(btn_press), 8'h00);
    end
    settle('0, 8);
    clear_all();

    // Randomized phase: sparse bit flips, clears and resets.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_BTN; i++)
        if ($urandom_range(0, 5) == 0) btn_in[i] = ~btn_in[i];
      event_clr = ($urandom_range(0, 7) == 0) ? NUM_BTN'($urandom) : '0;
      rst       = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      chk_model("rand");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
